// File: rtl/bcd_down_cnt_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_down_cnt_if
// Description : Control/data bundle for the two-digit BCD down-counter.
//               master drives the control side (en, load, data) and observes
//               the count; slave is the counter itself.
//   en    : count enable, active-high
//   load  : synchronous parallel load, active-low
//   data  : load value, BCD {tens, ones}
//   dout  : registered count, BCD {tens, ones}
//   bout  : borrow, high when the next edge decrements 00
//   zero  : high while dout == 00
//   done  : one-cycle pulse on arrival at 00 by decrement
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_down_cnt_if;
  logic       en;
  logic       load;
  logic [7:0] data;
  logic [7:0] dout;
  logic       bout;
  logic       zero;
  logic       done;

  modport master (
    output en, load, data,
    input  dout, bout, zero, done
  );

  modport slave (
    input  en, load, data,
    output dout, bout, zero, done
  );
endinterface
`default_nettype wire

// File: rtl/bcd_down_cnt.sv
`default_nettype none
// ============================================================================
// Module      : bcd_down_cnt
// Description : Two-digit BCD down-counter (99..00) with synchronous
//               active-low load, count enable, borrow output for cascading,
//               zero flag and a registered terminal-count pulse.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (count <= RST_VAL)
//   bus   : bcd_down_cnt_if.slave (en, load, data in; dout, bout, zero,
//           done out)
//   WRAP    : 1 = 00 wraps to 99 on decrement, 0 = sticks at 00
//   RST_VAL : BCD reset value {tens, ones}
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_down_cnt #(
  parameter bit         WRAP    = 1'b1,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  wire logic     clk,
  input  wire logic     rst,
  bcd_down_cnt_if.slave bus
);

  // Any nibble above 9 is forced to 9 so the count never leaves BCD.
  function automatic logic [3:0] clamp9(input logic [3:0] nib);
    return (nib > 4'd9) ? 4'd9 : nib;
  endfunction

  // Reset value goes through the same clamp as loaded data.
  localparam logic [7:0] c_rst_val = {clamp9(RST_VAL[7:4]), clamp9(RST_VAL[3:0])};
  localparam logic [7:0] c_bcd_99  = 8'h99;
  localparam logic [7:0] c_bcd_00  = 8'h00;
  localparam logic [7:0] c_bcd_01  = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] dout_q,  dout_d;
  logic       done_q,  done_d;

  logic [7:0] w_data_bcd;
  logic [3:0] w_ones;
  logic [3:0] w_tens;
  logic       w_zero;

  assign w_data_bcd = {clamp9(bus.data[7:4]), clamp9(bus.data[3:0])};
  assign w_ones     = dout_q[3:0];
  assign w_tens     = dout_q[7:4];
  assign w_zero     = (dout_q == c_bcd_00);

  // --------------------------------------------------------------------------
  // Next-state / next-count logic. Priority below reset: load > enable > hold.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    done_d  = 1'b0;       // pulse: cleared unless a fresh 01 -> 00 occurs

    if (!bus.load) begin
      dout_d  = w_data_bcd;
      state_d = (w_data_bcd != c_bcd_00) ? ST_RUN : ST_IDLE;
    end else if (bus.en) begin
      if (w_zero) begin
        // Terminal case: wrap to 99 or stay parked at 00 in the current
        // state (IDLE or EXPIRED) until a load or reset.
        if (WRAP) begin
          dout_d  = c_bcd_99;
          state_d = ST_RUN;
        end
      end else if (dout_q == c_bcd_01) begin
        dout_d  = c_bcd_00;
        state_d = ST_EXPIRED;
        done_d  = 1'b1;
      end else if (w_ones != 4'd0) begin
        dout_d  = {w_tens, w_ones - 4'd1};
        state_d = ST_RUN;
      end else begin
        // Ones borrow from tens; tens is non-zero here because 00 was
        // handled above.
        dout_d  = {w_tens - 4'd1, 4'd9};
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dout_q  <= c_rst_val;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  assign bus.dout = dout_q;
  assign bus.zero = w_zero;
  assign bus.done = done_q;
  // Borrow looks ahead to the coming edge: it only fires when that edge will
  // actually decrement 00 (no reset, no load, enabled).
  assign bus.bout = bus.en & bus.load & ~rst & w_zero;

endmodule
`default_nettype wire

// File: tb/tb_bcd_down_cnt.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_down_cnt
// Description : Scoreboard bench for bcd_down_cnt. Two instances share the
//               same stimulus: u_w (WRAP=1, RST_VAL=00) and u_n (WRAP=0,
//               RST_VAL=25). Each directed vector carries hand-computed
//               expectations that are queued; a monitor pops them, checks
//               bout before the edge and dout/zero/done after it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_down_cnt;

  logic clk;
  logic rst;

  bcd_down_cnt_if w_if ();
  bcd_down_cnt_if n_if ();

  bcd_down_cnt #(.WRAP(1'b1), .RST_VAL(8'h00)) u_w (
    .clk (clk),
    .rst (rst),
    .bus (w_if.slave)
  );

  bcd_down_cnt #(.WRAP(1'b0), .RST_VAL(8'h25)) u_n (
    .clk (clk),
    .rst (rst),
    .bus (n_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic       bw;
    logic [7:0] dw;
    logic       donew;
    logic       bn;
    logic [7:0] dn;
    logic       donen;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   vec_no = 0;

  task automatic chk(input string name, input int idx,
                     input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp_v);
    end
  endtask

  // Apply one cycle of stimulus at the falling edge and queue what both
  // counters must show: borrow before the edge, count/done after it.
  task automatic vec(input logic r, input logic e, input logic l,
                     input logic [7:0] d,
                     input logic bw, input logic [7:0] dw, input logic donew,
                     input logic bn, input logic [7:0] dn, input logic donen);
    exp_t it;
    @(negedge clk);
    rst       = r;
    w_if.en   = e;  w_if.load = l;  w_if.data = d;
    n_if.en   = e;  n_if.load = l;  n_if.data = d;
    it.idx = vec_no; it.bw = bw; it.dw = dw; it.donew = donew;
    it.bn  = bn;     it.dn = dn; it.donen = donen;
    q.push_back(it);
    vec_no++;
  endtask

  // Monitor
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
        it = q.pop_front();
        chk("w_bout", it.idx, {7'd0, w_if.bout}, {7'd0, it.bw});
        chk("n_bout", it.idx, {7'd0, n_if.bout}, {7'd0, it.bn});
        @(posedge clk);
        #1;
        chk("w_dout", it.idx, w_if.dout, it.dw);
        chk("w_zero", it.idx, {7'd0, w_if.zero}, {7'd0, (it.dw == 8'h00)});
        chk("w_done", it.idx, {7'd0, w_if.done}, {7'd0, it.donew});
        chk("n_dout", it.idx, n_if.dout, it.dn);
        chk("n_zero", it.idx, {7'd0, n_if.zero}, {7'd0, (it.dn == 8'h00)});
        chk("n_done", it.idx, {7'd0, n_if.done}, {7'd0, it.donen});
      end
    end
  end

  // Stimulus
  initial begin
    logic [7:0] seq12 [12];
    logic [7:0] seq_a [4];
    logic [7:0] seq_b [3];
    int         k;
    seq12 = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
              8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    seq_a = '{8'h03, 8'h03, 8'h03, 8'h03};
    seq_b = '{8'h02, 8'h01, 8'h00};

    rst = 1'b1;
    w_if.en = 1'b0; w_if.load = 1'b1; w_if.data = 8'h00;
    n_if.en = 1'b0; n_if.load = 1'b1; n_if.data = 8'h00;

    // Reset: two edges, borrow suppressed while in reset
    //   r  e  l  data    bw dw     dnw  bn dn     dnn
    vec(1, 1, 1, 8'h00,  0, 8'h00, 0,   0, 8'h25, 0);
    vec(1, 1, 1, 8'h00,  0, 8'h00, 0,   0, 8'h25, 0);
    // Release with EN: W borrows and wraps, N decrements 25
    vec(0, 1, 1, 8'h00,  1, 8'h99, 0,   0, 8'h24, 0);

    // Load 12 and count down; DONE only on the 12th edge
    vec(0, 0, 0, 8'h12,  0, 8'h12, 0,   0, 8'h12, 0);
    for (int i = 0; i < 12; i++)
      vec(0, 1, 1, 8'h00, 0, seq12[i], (i == 11), 0, seq12[i], (i == 11));
    vec(0, 0, 1, 8'h00,  0, 8'h00, 0,   0, 8'h00, 0);
    // Expired: W wraps without DONE, N sticks at 00
    vec(0, 1, 1, 8'h00,  1, 8'h99, 0,   1, 8'h00, 0);
    vec(0, 1, 1, 8'h00,  0, 8'h98, 0,   1, 8'h00, 0);

    // Borrow across digit
    vec(0, 0, 0, 8'h10,  0, 8'h10, 0,   0, 8'h10, 0);
    vec(0, 1, 1, 8'h00,  0, 8'h09, 0,   0, 8'h09, 0);
    // Load 00 with EN high: no DONE, then borrow and terminal case
    vec(0, 1, 0, 8'h00,  0, 8'h00, 0,   0, 8'h00, 0);
    vec(0, 1, 1, 8'h00,  1, 8'h99, 0,   1, 8'h00, 0);

    // Priority and clamp
    vec(0, 1, 0, 8'h3C,  0, 8'h39, 0,   0, 8'h39, 0);
    vec(0, 0, 0, 8'hAF,  0, 8'h99, 0,   0, 8'h99, 0);

    // Enable gating: 05 -> 03, hold 4 edges, then 3 more to 00
    vec(0, 0, 0, 8'h05,  0, 8'h05, 0,   0, 8'h05, 0);
    vec(0, 1, 1, 8'h00,  0, 8'h04, 0,   0, 8'h04, 0);
    vec(0, 1, 1, 8'h00,  0, 8'h03, 0,   0, 8'h03, 0);
    for (int i = 0; i < 4; i++)
      vec(0, 0, 1, 8'h00, 0, seq_a[i], 0, 0, seq_a[i], 0);
    for (int i = 0; i < 3; i++)
      vec(0, 1, 1, 8'h00, 0, seq_b[i], (i == 2), 0, seq_b[i], (i == 2));
    vec(0, 0, 1, 8'h00,  0, 8'h00, 0,   0, 8'h00, 0);

    // Reset mid-count at 47 (load/data ignored during reset)
    vec(0, 0, 0, 8'h47,  0, 8'h47, 0,   0, 8'h47, 0);
    vec(1, 1, 0, 8'h12,  0, 8'h00, 0,   0, 8'h25, 0);
    // Reset on the edge that would have produced DONE drops it
    vec(0, 0, 0, 8'h01,  0, 8'h01, 0,   0, 8'h01, 0);
    vec(1, 1, 1, 8'h00,  0, 8'h00, 0,   0, 8'h25, 0);
    // Subsequent load of 02 behaves normally
    vec(0, 0, 0, 8'h02,  0, 8'h02, 0,   0, 8'h02, 0);
    vec(0, 1, 1, 8'h00,  0, 8'h01, 0,   0, 8'h01, 0);
    vec(0, 1, 1, 8'h00,  0, 8'h00, 1,   0, 8'h00, 1);
    vec(0, 1, 1, 8'h00,  1, 8'h99, 0,   1, 8'h00, 0);
    vec(0, 1, 1, 8'h00,  0, 8'h98, 0,   1, 8'h00, 0);

    // Drain the scoreboard within a bounded number of cycles
    k = 0;
    while (q.size() != 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_down_cnt.md
# bcd_down_cnt

Two-digit BCD down-counter with synchronous load, count enable, borrow output and terminal-count pulse. It is the decrementing counterpart of the lab's loadable decade up-counter. It decrements through 99..00 instead of incrementing through 0..9, and exports a borrow (BOUT) for cascading, as the up-counter exports carry. It sits in the lab top level as a countdown/timer stage driven by the board clock and the same EN/LOAD/DATA switch set.

## Interface
- WRAP, default 1: 1 = count wraps 00 -> 99; 0 = count sticks at 00 until reloaded or reset.
- RST_VAL, default 8'h00: BCD value {tens, ones} loaded by reset.
- CLK  in  1  rising-edge clock, single clock domain.
- RST  in  1  reset, synchronous, active-high.
- EN  in  1  count enable, active-high.
- LOAD  in  1  synchronous parallel load, active-low.
- DATA  in  8  load value, BCD: [7:4] tens, [3:0] ones.
- DOUT  out  8  current count, BCD: [7:4] tens, [3:0] ones; registered.
- BOUT  out  1  borrow: combinational, high when the next edge will decrement 00.
- ZERO  out  1  high when DOUT == 8'h00; combinational from the register.
- DONE  out  1  registered one-cycle pulse marking arrival at 00 by decrement.

## Operation
- Per-edge priority: RST > LOAD=0 > EN=1 > hold.
- RST=1: DOUT <= RST_VAL, DONE <= 0, state <= IDLE. LOAD, EN and DATA are ignored that cycle.
- LOAD=0: DOUT <= sanitized DATA and DONE <= 0. The load happens regardless of EN. State becomes RUN if the loaded value != 00, otherwise IDLE.
- DATA sanitizing: any nibble > 9 is clamped to 9. Example: 8'hAF loads as 8'h99.
- EN=1 with no load decrements the count:
  - Ones digit: ones != 0 -> ones - 1. Ones == 0 -> ones = 9 and tens is decremented.
  - Tens digit: tens != 0 -> tens - 1. Tens == 0 with ones == 0 -> terminal case.
  - Terminal case: WRAP=1 -> 99. WRAP=0 -> hold 00.
- No digit outside 0..9 ever appears on DOUT.
- EN=0 with no load: DOUT holds, state holds.
- State machine, three states:
  - IDLE: count == 00, not armed.
  - RUN: count != 00.
  - EXPIRED: reached 00 by decrement.
- Transitions:
  - RUN -> EXPIRED on the decrement 01 -> 00. DONE is set to 1 on that same edge.
  - EXPIRED, WRAP=1, EN=1 -> RUN (DOUT becomes 99).
  - EXPIRED, WRAP=0: stays EXPIRED until LOAD or RST.
  - Any state -> per load rule on LOAD=0.
- DONE is high for exactly one cycle: it clears on the next edge unless a new 01 -> 00 decrement occurs.
- BOUT = EN & LOAD & ~RST & (DOUT == 00). It is asserted in both WRAP modes. For cascading, a lower stage's BOUT drives the next stage's EN.
- ZERO = (DOUT == 00), independent of EN.

## Timing
- All state updates occur on the CLK rising edge. Load-to-DOUT latency is 1 cycle; decrement latency is 1 cycle per count.
- Reset values: DOUT = RST_VAL, DONE = 0. ZERO and BOUT follow combinationally; BOUT = 0 while RST = 1.
- From load value N (BCD, N != 0) with EN held high, DOUT reaches 00 after exactly N edges. DONE is high during the cycle DOUT == 00.
- Simultaneous LOAD=0 and EN=1: the load wins and no decrement occurs that cycle.
- Reset mid-count: DOUT = RST_VAL on the next edge. A pending DONE is dropped.
- Loading 00 never produces DONE. Decrementing 00 -> 99 (WRAP=1) never produces DONE.
- Deasserting EN for k cycles delays expiry by exactly k cycles. DOUT is unchanged during the gap.

## Test plan
- Reset: RST=1 for 2 edges with RST_VAL=8'h00 -> DOUT=00, ZERO=1, DONE=0, BOUT=0. Release RST with EN=1 and WRAP=1 -> BOUT=1 and next DOUT=99.
- Load and countdown: LOAD=0 with DATA=8'h12, then EN=1 -> DOUT steps 12, 11, 10, 09 … 01, 00. DONE is high only in the 00 cycle, 12 edges after the load.
- Borrow across digit and wrap: load 8'h10 then EN=1 -> 09 next. Load 8'h00 with WRAP=1 -> BOUT=1, next DOUT=99. With WRAP=0 -> DOUT stays 00 and DONE stays 0.
- Priority and clamp: LOAD=0 with EN=1 and DATA=8'h3C -> DOUT=39 with no decrement that cycle. A load with EN=0 also takes effect.
- Enable gating: load 05, run 2 edges (03), EN=0 for 4 edges -> DOUT holds 03. Re-enable -> 00 after 3 more edges with a single DONE pulse.
- Reset mid-count: at DOUT=47, RST=1 for 1 edge -> DOUT=RST_VAL, DONE=0, state IDLE. A subsequent load of 02 behaves normally.
